// File: rtl/huff_decoder_if.sv
// Beat bus for the Huffman decoder: one 12-bit command beat in, one 12-bit status word out.
interface huff_decoder_if;
   logic [11:0] io_in;
   logic [11:0] io_out;

   modport master (output io_in, input io_out);
   modport slave  (input io_in, output io_out);
endinterface

// File: rtl/huff_decoder.sv
// Three-entry Huffman decoder: table load via SYM/CODE beats, bit stream via BITS beats,
// one bit popped per cycle from a small bit FIFO and matched against the code table.
//
// state | meaning
// CFG   | table incomplete (table_ok=0); BITS beats are dropped
// IDLE  | table complete, FIFO empty and no partial code held
// SHIFT | bits pending in the FIFO or a partial code in the accumulator
module huff_decoder #(
   parameter int FIFO_DEPTH = 8
) (
   input logic clk,
   input logic reset,
   huff_decoder_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] DEPTH_U = 32'(FIFO_DEPTH);

   typedef enum logic [1:0] {CFG, IDLE, SHIFT} state_t;

   state_t state_q, state_n;
   logic [7:0] sym_q [3];
   logic [7:0] sym_n [3];
   logic [1:0] len_q [3];
   logic [1:0] len_n [3];
   logic [2:0] val_q [3];
   logic [2:0] val_n [3];
   logic [2:0] sym_ok_q, sym_ok_n;
   logic [1:0] sptr_q, sptr_n;
   logic table_ok_q, table_ok_n;
   logic [FIFO_DEPTH-1:0] fifo_q, fifo_n;
   logic [CW-1:0] cnt_q, cnt_n, cnt_mid;
   logic [2:0] acc_q, acc_n, acc_new, mask;
   logic [1:0] acc_len_q, acc_len_n, len_new;
   logic [7:0] char_q, char_n;
   logic char_v_q, char_v_n, err_q, err_n;

   logic beat_v;
   logic [1:0] op, nbits, hit_idx;
   logic [8:0] pl;
   logic is_sym, is_code, is_bits, is_ctrl, clr_tab, clr_fifo;
   logic room, push_ok, drop, pop, hit, in_ready;
   logic unused_pl;
   int base, off, nb;

   assign beat_v    = bus.io_in[11];
   assign op        = bus.io_in[10:9];
   assign pl        = bus.io_in[8:0];
   assign nbits     = pl[8:7];
   assign unused_pl = ^pl[4:3];
   assign is_sym    = beat_v && (op == 2'b00);
   assign is_code   = beat_v && (op == 2'b01);
   assign is_bits   = beat_v && (op == 2'b10);
   assign is_ctrl   = beat_v && (op == 2'b11);
   assign clr_tab   = is_ctrl && pl[0];
   assign clr_fifo  = is_ctrl && (pl[0] || pl[1]);

   // Capacity checks use the registered count, before this cycle's pop.
   assign room     = (32'(cnt_q) + 32'(nbits)) <= DEPTH_U;
   assign in_ready = (32'(cnt_q) + 32'd3) <= DEPTH_U;
   assign push_ok  = is_bits && (nbits != 2'd0) && table_ok_q && room;
   assign drop     = is_bits && (nbits != 2'd0) && !push_ok;
   assign pop      = (state_q == SHIFT) && (cnt_q != '0) && !clr_fifo;

   assign acc_new = {acc_q[1:0], fifo_q[0]};
   assign len_new = acc_len_q + 2'd1;
   assign mask    = (len_new == 2'd1) ? 3'b001 : (len_new == 2'd2) ? 3'b011 : 3'b111;

   always_comb begin
      hit     = 1'b0;
      hit_idx = 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (!hit && (len_q[i] == len_new) && (((val_q[i] ^ acc_new) & mask) == 3'b000)) begin
            hit     = 1'b1;
            hit_idx = 2'(i);
         end
      end
   end

   always_comb begin
      sym_ok_n = sym_ok_q;
      sptr_n   = sptr_q;
      for (int i = 0; i < 3; i++) begin
         sym_n[i] = sym_q[i];
         len_n[i] = len_q[i];
         val_n[i] = val_q[i];
      end
      if (is_sym) begin
         sym_n[sptr_q]    = pl[7:0];
         sym_ok_n[sptr_q] = 1'b1;
         sptr_n           = (sptr_q == 2'd2) ? 2'd0 : sptr_q + 2'd1;
      end
      if (is_code && (pl[8:7] != 2'd3)) begin
         len_n[pl[8:7]] = pl[6:5];
         val_n[pl[8:7]] = pl[2:0];
      end
      if (clr_tab) begin
         sym_ok_n = 3'b000;
         sptr_n   = 2'd0;
         for (int i = 0; i < 3; i++) begin
            sym_n[i] = 8'h00;
            len_n[i] = 2'd0;
            val_n[i] = 3'd0;
         end
      end
      table_ok_n = (&sym_ok_n) && (len_n[0] != 2'd0) && (len_n[1] != 2'd0) && (len_n[2] != 2'd0);
   end

   // New bits land directly behind whatever survives this cycle's pop.
   always_comb begin
      cnt_mid = pop ? cnt_q - CW'(1) : cnt_q;
      fifo_n  = pop ? (fifo_q >> 1) : fifo_q;
      base    = int'(cnt_mid);
      nb      = int'(nbits);
      off     = 0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         off = i - base;
         if (push_ok && (off >= 0) && (off < nb)) begin
            case (off)
               0:       fifo_n[i] = pl[2];
               1:       fifo_n[i] = pl[1];
               default: fifo_n[i] = pl[0];
            endcase
         end
      end
      cnt_n = push_ok ? cnt_mid + CW'(nbits) : cnt_mid;
      if (clr_fifo) begin
         fifo_n = '0;
         cnt_n  = '0;
      end
   end

   always_comb begin
      acc_n     = acc_q;
      acc_len_n = acc_len_q;
      if (pop) begin
         if (hit || (len_new == 2'd3)) begin
            acc_n     = 3'd0;
            acc_len_n = 2'd0;
         end else begin
            acc_n     = acc_new;
            acc_len_n = len_new;
         end
      end
      if (clr_fifo) begin
         acc_n     = 3'd0;
         acc_len_n = 2'd0;
      end
      char_v_n = pop && hit;
      char_n   = (pop && hit) ? sym_q[hit_idx] : char_q;
      err_n    = drop || (pop && !hit && (len_new == 2'd3));
   end

   always_comb begin
      state_n = state_q;
      if (!table_ok_n) begin
         state_n = CFG;
      end else begin
         case (state_q)
            CFG:     state_n = ((cnt_n != '0) || (acc_len_n != 2'd0)) ? SHIFT : IDLE;
            IDLE:    state_n = push_ok ? SHIFT : IDLE;
            SHIFT:   state_n = ((cnt_q == '0) && (acc_len_q == 2'd0) && !push_ok) ? IDLE : SHIFT;
            default: state_n = CFG;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CFG;
         sym_ok_q   <= 3'b000;
         sptr_q     <= 2'd0;
         table_ok_q <= 1'b0;
         fifo_q     <= '0;
         cnt_q      <= '0;
         acc_q      <= 3'd0;
         acc_len_q  <= 2'd0;
         char_q     <= 8'h00;
         char_v_q   <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            sym_q[i] <= 8'h00;
            len_q[i] <= 2'd0;
            val_q[i] <= 3'd0;
         end
      end else begin
         state_q    <= state_n;
         sym_ok_q   <= sym_ok_n;
         sptr_q     <= sptr_n;
         table_ok_q <= table_ok_n;
         fifo_q     <= fifo_n;
         cnt_q      <= cnt_n;
         acc_q      <= acc_n;
         acc_len_q  <= acc_len_n;
         char_q     <= char_n;
         char_v_q   <= char_v_n;
         err_q      <= err_n;
         for (int i = 0; i < 3; i++) begin
            sym_q[i] <= sym_n[i];
            len_q[i] <= len_n[i];
            val_q[i] <= val_n[i];
         end
      end
   end

   assign bus.io_out = reset ? 12'h000 : {table_ok_q, in_ready, err_q, char_v_q, char_q};
endmodule

// File: tb/tb_huff_decoder.sv
// Directed bench for huff_decoder: table load, decoding, bad codes, overflow and resets.
module tb_huff_decoder;
   logic clk = 1'b0;
   logic reset;
   huff_decoder_if bus ();

   huff_decoder #(.FIFO_DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic t_ok, rdy, err, cv;
   logic [7:0] ch;
   assign {t_ok, rdy, err, cv, ch} = bus.io_out;

   function automatic logic [11:0] sym_beat(input logic [7:0] c);
      return {1'b1, 2'b00, 1'b0, c};
   endfunction
   function automatic logic [11:0] code_beat(input logic [1:0] idx, input logic [1:0] len, input logic [2:0] val);
      return {1'b1, 2'b01, idx, len, 2'b00, val};
   endfunction
   function automatic logic [11:0] bits_beat(input logic [1:0] n, input logic [2:0] b);
      return {1'b1, 2'b10, n, 4'b0000, b};
   endfunction
   function automatic logic [11:0] ctrl_beat(input logic [1:0] p);
      return {1'b1, 2'b11, 7'b0000000, p};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [11:0] v);
      bus.io_in = v;
      @(posedge clk);
      #1;
      bus.io_in = 12'h000;
   endtask

   task automatic load_basic();
      send(sym_beat(8'h61));
      send(sym_beat(8'h62));
      send(sym_beat(8'h63));
      send(code_beat(2'd0, 2'd1, 3'b000));
      send(code_beat(2'd1, 2'd2, 3'b010));
      send(code_beat(2'd2, 2'd2, 3'b011));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.io_in = sym_beat(8'h41);
      step();
      step();
      checks++;
      if (bus.io_out !== 12'h000) begin failures++; $display("FAIL rst_io_out got=%h exp=%h", bus.io_out, 12'h000); end
      reset = 1'b0;
      bus.io_in = 12'h000;
      #1;
      checks++;
      if (bus.io_out !== 12'h400) begin failures++; $display("FAIL rst_first_cycle got=%h exp=%h", bus.io_out, 12'h400); end
   endtask

   task automatic test_table_load();
      logic [7:0] syms [3];
      syms[0] = 8'h61; syms[1] = 8'h62; syms[2] = 8'h63;
      for (int i = 0; i < 3; i++) begin
         send(sym_beat(syms[i]));
         checks++;
         if (t_ok !== 1'b0) begin failures++; $display("FAIL load_sym%0d table_ok got=%b exp=0", i, t_ok); end
      end
      send(code_beat(2'd0, 2'd1, 3'b000));
      send(code_beat(2'd1, 2'd2, 3'b010));
      checks++;
      if (t_ok !== 1'b0) begin failures++; $display("FAIL load_code1 table_ok got=%b exp=0", t_ok); end
      send(code_beat(2'd2, 2'd2, 3'b011));
      checks++;
      if (t_ok !== 1'b1) begin failures++; $display("FAIL load_done table_ok got=%b exp=1", t_ok); end
   endtask

   task automatic test_basic_decode();
      send(bits_beat(2'd0, 3'b111));
      checks++;
      if (err !== 1'b0 || cv !== 1'b0) begin failures++; $display("FAIL bits_n0 err=%b cv=%b exp 0 0", err, cv); end
      send(bits_beat(2'd3, 3'b010));
      send(bits_beat(2'd2, 3'b110));
      checks++;
      if (cv !== 1'b1 || ch !== 8'h61) begin failures++; $display("FAIL dec_a cv=%b ch=%h exp 1 61", cv, ch); end
      step();
      checks++;
      if (cv !== 1'b0) begin failures++; $display("FAIL dec_a_pulse cv=%b exp 0", cv); end
      step();
      checks++;
      if (cv !== 1'b1 || ch !== 8'h62) begin failures++; $display("FAIL dec_b cv=%b ch=%h exp 1 62", cv, ch); end
      step();
      checks++;
      if (cv !== 1'b0 || ch !== 8'h62) begin failures++; $display("FAIL dec_hold cv=%b ch=%h exp 0 62", cv, ch); end
      step();
      checks++;
      if (cv !== 1'b1 || ch !== 8'h63) begin failures++; $display("FAIL dec_c cv=%b ch=%h exp 1 63", cv, ch); end
      step();
      checks++;
      if (cv !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL dec_end cv=%b err=%b exp 0 0", cv, err); end
   endtask

   task automatic test_partial_hold();
      int pulses = 0;
      send(bits_beat(2'd1, 3'b100));
      for (int i = 0; i < 6; i++) begin
         step();
         pulses += int'(cv) + int'(err);
      end
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL partial_hold pulses=%0d exp 0", pulses); end
      send(bits_beat(2'd1, 3'b100));
      step();
      checks++;
      if (cv !== 1'b1 || ch !== 8'h63) begin failures++; $display("FAIL partial_done cv=%b ch=%h exp 1 63", cv, ch); end
   endtask

   task automatic test_ctrl_flush();
      send(bits_beat(2'd1, 3'b100));
      step();
      send(ctrl_beat(2'b10));
      checks++;
      if (t_ok !== 1'b1 || cv !== 1'b0) begin failures++; $display("FAIL flush_keep table_ok=%b cv=%b exp 1 0", t_ok, cv); end
      send(bits_beat(2'd1, 3'b000));
      step();
      checks++;
      if (cv !== 1'b1 || ch !== 8'h61) begin failures++; $display("FAIL flush_acc cv=%b ch=%h exp 1 61", cv, ch); end
   endtask

   task automatic test_bad_code();
      step();
      send(code_beat(2'd0, 2'd3, 3'b000));
      send(code_beat(2'd1, 2'd3, 3'b001));
      send(code_beat(2'd2, 2'd3, 3'b010));
      checks++;
      if (t_ok !== 1'b1) begin failures++; $display("FAIL bad_table table_ok=%b exp 1", t_ok); end
      send(bits_beat(2'd3, 3'b111));
      step();
      step();
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL bad_early err=%b exp 0", err); end
      step();
      checks++;
      if (err !== 1'b1 || cv !== 1'b0) begin failures++; $display("FAIL bad_err err=%b cv=%b exp 1 0", err, cv); end
      step();
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL bad_err_pulse err=%b exp 0", err); end
      send(bits_beat(2'd3, 3'b001));
      step();
      step();
      checks++;
      if (cv !== 1'b0) begin failures++; $display("FAIL bad_next_early cv=%b exp 0", cv); end
      step();
      checks++;
      if (cv !== 1'b1 || ch !== 8'h62) begin failures++; $display("FAIL bad_next cv=%b ch=%h exp 1 62", cv, ch); end
   endtask

   task automatic test_duplicate_codes();
      step();
      send(code_beat(2'd0, 2'd1, 3'b001));
      send(code_beat(2'd1, 2'd2, 3'b000));
      send(code_beat(2'd2, 2'd1, 3'b001));
      send(bits_beat(2'd1, 3'b100));
      step();
      checks++;
      if (cv !== 1'b1 || ch !== 8'h61) begin failures++; $display("FAIL dup_codes cv=%b ch=%h exp 1 61", cv, ch); end
   endtask

   task automatic test_overflow();
      int pulses = 0;
      int errs = 0;
      step();
      send(ctrl_beat(2'b01));
      checks++;
      if (t_ok !== 1'b0) begin failures++; $display("FAIL ovf_clear table_ok=%b exp 0", t_ok); end
      send(bits_beat(2'd3, 3'b000));
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL ovf_cfg_drop err=%b exp 1", err); end
      step();
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL ovf_cfg_pulse err=%b exp 0", err); end
      load_basic();
      send(bits_beat(2'd3, 3'b000));
      pulses += int'(cv);
      checks++;
      if (rdy !== 1'b1) begin failures++; $display("FAIL ovf_rdy1 in_ready=%b exp 1", rdy); end
      send(bits_beat(2'd3, 3'b000));
      pulses += int'(cv);
      checks++;
      if (rdy !== 1'b1) begin failures++; $display("FAIL ovf_rdy2 in_ready=%b exp 1", rdy); end
      send(bits_beat(2'd3, 3'b000));
      pulses += int'(cv);
      checks++;
      if (rdy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL ovf_rdy3 in_ready=%b err=%b exp 0 0", rdy, err); end
      send(bits_beat(2'd3, 3'b000));
      pulses += int'(cv);
      checks++;
      if (err !== 1'b1 || rdy !== 1'b0) begin failures++; $display("FAIL ovf_drop err=%b in_ready=%b exp 1 0", err, rdy); end
      checks++;
      if (dut.cnt_q > 4'd8) begin failures++; $display("FAIL ovf_count count=%0d exp <=8", dut.cnt_q); end
      for (int i = 0; i < 20; i++) begin
         step();
         pulses += int'(cv);
         errs += int'(err);
      end
      checks++;
      if (pulses != 9 || errs != 0) begin failures++; $display("FAIL ovf_drain pulses=%0d errs=%0d exp 9 0", pulses, errs); end
      checks++;
      if (rdy !== 1'b1) begin failures++; $display("FAIL ovf_rdy_end in_ready=%b exp 1", rdy); end
   endtask

   task automatic test_reset_mid_decode();
      int pulses = 0;
      send(bits_beat(2'd3, 3'b111));
      send(bits_beat(2'd2, 3'b110));
      reset = 1'b1;
      step();
      checks++;
      if (bus.io_out !== 12'h000) begin failures++; $display("FAIL mid_rst_out got=%h exp 000", bus.io_out); end
      step();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.io_out !== 12'h400) begin failures++; $display("FAIL mid_rst_release got=%h exp 400", bus.io_out); end
      for (int i = 0; i < 5; i++) begin
         step();
         pulses += int'(cv);
      end
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL mid_rst_pulses got=%0d exp 0", pulses); end
      send(bits_beat(2'd3, 3'b000));
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL mid_rst_needs_table err=%b exp 1", err); end
      load_basic();
      send(bits_beat(2'd2, 3'b100));
      step();
      step();
      checks++;
      if (cv !== 1'b1 || ch !== 8'h62) begin failures++; $display("FAIL mid_rst_reload cv=%b ch=%h exp 1 62", cv, ch); end
   endtask

   initial begin
      reset = 1'b1;
      bus.io_in = 12'h000;
      test_reset();
      test_table_load();
      test_basic_decode();
      test_partial_hold();
      test_ctrl_flush();
      test_bad_code();
      test_duplicate_codes();
      test_overflow();
      test_reset_mid_decode();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
